// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared widths, owner encodings and helpers for the data-memory arbiter.
// Owner encodings match the DARB_IDLE / DARB_OWN0 / DARB_OWN1 values used elsewhere in the core.
package riscv_dmem_arbiter_pkg;

  localparam int XLEN          = 32;
  localparam int DMEM_ADDR_BIT = 12;
  localparam int DMEM_AW       = DMEM_ADDR_BIT - 2;
  localparam int BSEL_W        = XLEN / 8;
  localparam int BURST_W       = 4;

  localparam logic [BURST_W-1:0] BURST_SAT = 4'd15;

  typedef enum logic [1:0] {
    DARB_IDLE = 2'd0,
    DARB_OWN0 = 2'd1,
    DARB_OWN1 = 2'd2
  } darb_owner_e;

  function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] cnt);
    return (cnt == BURST_SAT) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/riscv_dmem_arb_rr.sv
// Owner FSM, burst counter and grant decode for the two-port data-memory arbiter.
// state     | meaning
// DARB_IDLE | nobody requested last cycle; a tie goes to port 0
// DARB_OWN0 | port 0 was granted last cycle
// DARB_OWN1 | port 1 was granted last cycle
module riscv_dmem_arb_rr
  import riscv_dmem_arbiter_pkg::*;
#(
  parameter int RR_EN     = 1,
  parameter int MAX_GRANT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  localparam logic [BURST_W-1:0] MAX_G = BURST_W'(MAX_GRANT);

  darb_owner_e        owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [1:0]         gnt_raw;
  logic               limit_hit;

  assign limit_hit = (burst_q >= MAX_G);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q <= DARB_IDLE;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    gnt_raw = 2'b00;
    owner_d = owner_q;
    burst_d = burst_q;

    case (i_req)
      2'b01: gnt_raw = 2'b01;
      2'b10: gnt_raw = 2'b10;
      2'b11: begin
        if ((RR_EN == 0) || (owner_q == DARB_IDLE)) begin
          gnt_raw = 2'b01;
        end else if (owner_q == DARB_OWN0) begin
          gnt_raw = limit_hit ? 2'b10 : 2'b01;
        end else begin
          gnt_raw = limit_hit ? 2'b01 : 2'b10;
        end
      end
      default: gnt_raw = 2'b00;
    endcase

    // The burst only grows while the loser keeps contending; a lone requester restarts at 1.
    if (gnt_raw == 2'b00) begin
      owner_d = DARB_IDLE;
      burst_d = '0;
    end else begin
      owner_d = gnt_raw[1] ? DARB_OWN1 : DARB_OWN0;
      if ((owner_d == owner_q) && (&i_req)) begin
        burst_d = burst_inc(burst_q);
      end else begin
        burst_d = 4'd1;
      end
    end
  end

  assign o_gnt = i_rst ? 2'b00 : gnt_raw;

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (port 0 = LSU, port 1 = DMA/debug).
// Holds the request mux toward memory and the registered load-response path.
module riscv_dmem_arbiter
  import riscv_dmem_arbiter_pkg::*;
#(
  parameter int RR_EN     = 1,
  parameter int MAX_GRANT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic               i_wr0,
  input  logic               i_wr1,
  input  logic [DMEM_AW-1:0] i_addr0,
  input  logic [DMEM_AW-1:0] i_addr1,
  input  logic [BSEL_W-1:0]  i_bsel0,
  input  logic [BSEL_W-1:0]  i_bsel1,
  input  logic [XLEN-1:0]    i_wdata0,
  input  logic [XLEN-1:0]    i_wdata1,
  output logic               o_gnt0,
  output logic               o_gnt1,
  output logic               o_rvalid0,
  output logic               o_rvalid1,
  output logic [XLEN-1:0]    o_rdata,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic [BSEL_W-1:0]  o_dmem_bsel,
  output logic [XLEN-1:0]    o_dmem_wdata,
  output logic               o_dmem_wr_en,
  input  logic [XLEN-1:0]    i_dmem_rdata
);

  logic [1:0]      gnt;
  logic            load0, load1;
  logic            rvalid0_q, rvalid1_q;
  logic [XLEN-1:0] rdata_q;

  riscv_dmem_arb_rr #(
    .RR_EN     (RR_EN),
    .MAX_GRANT (MAX_GRANT)
  ) u_rr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req ({i_req1, i_req0}),
    .o_gnt (gnt)
  );

  assign o_gnt0 = gnt[0];
  assign o_gnt1 = gnt[1];

  always_comb begin
    o_dmem_addr  = '0;
    o_dmem_bsel  = '0;
    o_dmem_wdata = '0;
    o_dmem_wr_en = 1'b0;
    if (gnt[0]) begin
      o_dmem_addr  = i_addr0;
      o_dmem_bsel  = i_bsel0;
      o_dmem_wdata = i_wdata0;
      o_dmem_wr_en = i_wr0;
    end else if (gnt[1]) begin
      o_dmem_addr  = i_addr1;
      o_dmem_bsel  = i_bsel1;
      o_dmem_wdata = i_wdata1;
      o_dmem_wr_en = i_wr1;
    end
  end

  assign load0 = gnt[0] & ~i_wr0;
  assign load1 = gnt[1] & ~i_wr1;

  // Read data is shared; it only moves on a granted load so it holds between loads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid0_q <= load0;
      rvalid1_q <= load1;
      if (load0 || load1) begin
        rdata_q <= i_dmem_rdata;
      end
    end
  end

  assign o_rvalid0 = rvalid0_q;
  assign o_rvalid1 = rvalid1_q;
  assign o_rdata   = rdata_q;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: a round-robin instance (MAX_GRANT=4) and a fixed-priority
// instance share stimulus; a behavioural model predicts grants, memory drive and load data.
module tb_riscv_dmem_arbiter;
  import riscv_dmem_arbiter_pkg::*;

  localparam int MAXG  = 4;
  localparam int WORDS = 1 << DMEM_AW;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1, wr0, wr1;
  logic [DMEM_AW-1:0] addr0, addr1;
  logic [BSEL_W-1:0]  bsel0, bsel1;
  logic [XLEN-1:0]    wdata0, wdata1;

  logic gnt0_a, gnt1_a, rv0_a, rv1_a, we_a;
  logic [XLEN-1:0] rdata_a, wd_a, mrd_a;
  logic [DMEM_AW-1:0] ma_a;
  logic [BSEL_W-1:0]  mb_a;

  logic gnt0_b, gnt1_b, rv0_b, rv1_b, we_b;
  logic [XLEN-1:0] rdata_b, wd_b, mrd_b;
  logic [DMEM_AW-1:0] ma_b;
  logic [BSEL_W-1:0]  mb_b;

  logic [XLEN-1:0] mem_a [WORDS];
  logic [XLEN-1:0] mem_b [WORDS];
  logic            mem_clr;

  always #5 clk = ~clk;

  riscv_dmem_arbiter #(.RR_EN(1), .MAX_GRANT(MAXG)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
    .i_addr0(addr0), .i_addr1(addr1), .i_bsel0(bsel0), .i_bsel1(bsel1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0_a), .o_gnt1(gnt1_a), .o_rvalid0(rv0_a), .o_rvalid1(rv1_a),
    .o_rdata(rdata_a), .o_dmem_addr(ma_a), .o_dmem_bsel(mb_a),
    .o_dmem_wdata(wd_a), .o_dmem_wr_en(we_a), .i_dmem_rdata(mrd_a)
  );

  riscv_dmem_arbiter #(.RR_EN(0), .MAX_GRANT(MAXG)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
    .i_addr0(addr0), .i_addr1(addr1), .i_bsel0(bsel0), .i_bsel1(bsel1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0_b), .o_gnt1(gnt1_b), .o_rvalid0(rv0_b), .o_rvalid1(rv1_b),
    .o_rdata(rdata_b), .o_dmem_addr(ma_b), .o_dmem_bsel(mb_b),
    .o_dmem_wdata(wd_b), .o_dmem_wr_en(we_b), .i_dmem_rdata(mrd_b)
  );

  assign mrd_a = mem_a[ma_a];
  assign mrd_b = mem_b[ma_b];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BSEL_W; i++) begin
        if (we_a && mb_a[i]) mem_a[ma_a][8*i +: 8] <= wd_a[8*i +: 8];
        if (we_b && mb_b[i]) mem_b[ma_b][8*i +: 8] <= wd_b[8*i +: 8];
      end
    end
  end

  // Reference model: last granted port (-1 = none) and length of the contested run.
  int last_a, streak_a, last_b, streak_b;
  logic [XLEN-1:0] ref_mem [WORDS];
  logic            erv0_a, erv1_a, erv0_b, erv1_b;
  logic [XLEN-1:0] exp_rdata_a;
  logic [1:0]      seen_a;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int model_gnt(input int rr, input int last, input int streak,
                                   input logic r0, input logic r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (rr == 0 || last < 0) return 0;
    return (streak < MAXG) ? last : 1 - last;
  endfunction

  task automatic model_upd(inout int last, inout int streak, input int g, input logic both);
    if (g < 0) begin
      last = -1;
      streak = 0;
    end else begin
      if (g == last && both) streak = (streak < 15) ? streak + 1 : 15;
      else streak = 1;
      last = g;
    end
  endtask

  task automatic model_reset();
    last_a = -1; streak_a = 0;
    last_b = -1; streak_b = 0;
    erv0_a = 1'b0; erv1_a = 1'b0; erv0_b = 1'b0; erv1_b = 1'b0;
    exp_rdata_a = '0;
  endtask

  // One clock: inputs were driven just after the previous edge.
  task automatic step();
    int ga, gb;
    logic               pwr;
    logic [DMEM_AW-1:0] pa;
    logic [BSEL_W-1:0]  pb;
    logic [XLEN-1:0]    pw;
    #2;
    ga = model_gnt(1, last_a, streak_a, req0, req1);
    gb = model_gnt(0, last_b, streak_b, req0, req1);
    seen_a = {gnt1_a, gnt0_a};
    pwr = 1'b0; pa = '0; pb = '0; pw = '0;
    if (ga == 0) begin pwr = wr0; pa = addr0; pb = bsel0; pw = wdata0; end
    else if (ga == 1) begin pwr = wr1; pa = addr1; pb = bsel1; pw = wdata1; end

    chk("gnt0_a", 32'(gnt0_a), 32'(ga == 0));
    chk("gnt1_a", 32'(gnt1_a), 32'(ga == 1));
    chk("gnt0_b", 32'(gnt0_b), 32'(gb == 0));
    chk("gnt1_b", 32'(gnt1_b), 32'(gb == 1));
    chk("wr_en_a", 32'(we_a), 32'(pwr));
    chk("addr_a", 32'(ma_a), 32'(pa));
    chk("bsel_a", 32'(mb_a), 32'(pb));
    chk("wdata_a", wd_a, pw);
    chk("wr_en_b", 32'(we_b), 32'((gb == 0 && wr0) || (gb == 1 && wr1)));

    erv0_a = (ga == 0) && !wr0;
    erv1_a = (ga == 1) && !wr1;
    erv0_b = (gb == 0) && !wr0;
    erv1_b = (gb == 1) && !wr1;
    if (ga >= 0) begin
      if (pwr) begin
        for (int i = 0; i < BSEL_W; i++)
          if (pb[i]) ref_mem[pa][8*i +: 8] = pw[8*i +: 8];
      end else begin
        exp_rdata_a = ref_mem[pa];
      end
    end
    model_upd(last_a, streak_a, ga, req0 & req1);
    model_upd(last_b, streak_b, gb, req0 & req1);

    @(posedge clk);
    #1;
    chk("rvalid0_a", 32'(rv0_a), 32'(erv0_a));
    chk("rvalid1_a", 32'(rv1_a), 32'(erv1_a));
    chk("rdata_a", rdata_a, exp_rdata_a);
    chk("rvalid0_b", 32'(rv0_b), 32'(erv0_b));
    chk("rvalid1_b", 32'(rv1_b), 32'(erv1_b));
  endtask

  task automatic reset_check();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_gnt0", 32'(gnt0_a), 32'(0));
    chk("rst_gnt1", 32'(gnt1_a), 32'(0));
    chk("rst_wr_en", 32'(we_a), 32'(0));
    chk("rst_rvalid0", 32'(rv0_a), 32'(0));
    chk("rst_rvalid1", 32'(rv1_a), 32'(0));
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_gnt_b", 32'({gnt1_b, gnt0_b}), 32'(0));
    @(posedge clk);
    #1;
    chk("rst_hold_rvalid0", 32'(rv0_a), 32'(0));
    chk("rst_hold_rdata", rdata_a, 32'h0);
    rst = 1'b0;
  endtask

  task automatic drive0(input logic r, input logic w, input logic [DMEM_AW-1:0] a,
                        input logic [BSEL_W-1:0] b, input logic [XLEN-1:0] d);
    req0 = r; wr0 = w; addr0 = a; bsel0 = b; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [DMEM_AW-1:0] a,
                        input logic [BSEL_W-1:0] b, input logic [XLEN-1:0] d);
    req1 = r; wr1 = w; addr1 = a; bsel1 = b; wdata1 = d;
  endtask

  function automatic logic [BSEL_W-1:0] rand_bsel();
    case ($urandom_range(0, 2))
      0:       return 4'b0001;
      1:       return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_clr = 1'b1;
    @(posedge clk);
    #1 mem_clr = 1'b0;
  end

  initial begin
    int pat3 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int pat6 [6]  = '{0, 0, 0, 0, 1, 1};

    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    seen_a = 2'b00;
    rst = 1'b1;
    drive0(1'b1, 1'b0, '0, 4'hF, '0);
    drive1(1'b1, 1'b0, '0, 4'hF, '0);

    // Reset with both requesting, then port 0 wins on release.
    reset_check();
    step();
    chk("t1_first_gnt", 32'(seen_a), 32'(2'b01));

    // Store then load back on port 0.
    drive1(1'b0, 1'b0, '0, '0, '0);
    drive0(1'b1, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
    step();
    drive0(1'b1, 1'b0, 10'h010, 4'hF, '0);
    step();
    chk("t2_rvalid0", 32'(rv0_a), 32'(1));
    chk("t2_rdata", rdata_a, 32'hDEADBEEF);

    // Idle, then continuous contention: four-grant bursts alternating.
    drive0(1'b0, 1'b0, '0, '0, '0);
    step();
    drive0(1'b1, 1'b0, 10'h010, 4'hF, '0);
    drive1(1'b1, 1'b0, 10'h011, 4'hF, '0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t3_pat%0d", i), 32'(seen_a), 32'(pat3[i] == 0 ? 2'b01 : 2'b10));
    end

    // Fixed priority instance keeps port 1 starved until port 0 lets go.
    for (int i = 0; i < 20; i++) step();
    drive0(1'b0, 1'b0, '0, '0, '0);
    #2;
    chk("t4_gnt1_b_release", 32'({gnt1_b, gnt0_b}), 32'(2'b10));
    #1;
    step();

    // Byte store merges into an existing word.
    drive1(1'b0, 1'b0, '0, '0, '0);
    drive0(1'b1, 1'b1, 10'h020, 4'hF, 32'h11223344);
    step();
    drive0(1'b1, 1'b1, 10'h020, 4'b0001, 32'h000000AA);
    step();
    drive0(1'b1, 1'b0, 10'h020, 4'hF, '0);
    step();
    chk("t5_rdata", rdata_a, 32'h112233AA);

    // Granted load then reset: response dropped, arbitration restarts from idle.
    drive0(1'b1, 1'b0, 10'h010, 4'hF, '0);
    step();
    reset_check();
    drive0(1'b1, 1'b0, 10'h010, 4'hF, '0);
    drive1(1'b1, 1'b0, 10'h020, 4'hF, '0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t6_pat%0d", i), 32'(seen_a), 32'(pat6[i] == 0 ? 2'b01 : 2'b10));
    end

    // Random traffic; an ungranted requester holds its request stable.
    for (int n = 0; n < 300; n++) begin
      if (!(req0 && !seen_a[0]))
        drive0($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
               DMEM_AW'($urandom_range(0, 15)), rand_bsel(), $urandom);
      if (!(req1 && !seen_a[1]))
        drive1($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
               DMEM_AW'($urandom_range(0, 15)), rand_bsel(), $urandom);
      if ($urandom_range(0, 99) == 0) begin
        reset_check();
        seen_a = 2'b00;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
